wr_fifo_arb: RTL and testbench
==============================

Name: wr_fifo_arb

Overview:
Round-robin write-side arbiter that shares one async-FIFO write port (wr_fifo_ctrl plus storage) among NUM_REQ requesters.
- Grants a requester for a burst that ends on the last-beat flag or after MAX_BURST beats, whichever comes first.
- Gates writes with the FIFO full flag.
- Tags each written word with the source requester ID so the read side can demultiplex.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
DATA_WDTH, 8, payload width per requester
MAX_BURST, 4, maximum beats per grant (1..256)
ID_WDTH, $clog2(NUM_REQ), tag width (derived, not overridable)

Ports:
clk  in  1  write-domain clock
rst_n  in  1  asynchronous active-low reset
sync_rst_n  in  1  synchronous active-low reset; same effect as rst_n
req_valid  in  NUM_REQ  per-requester beat valid
req_data  in  NUM_REQ*DATA_WDTH  payloads; requester i uses bits [i*DATA_WDTH +: DATA_WDTH]
req_last  in  NUM_REQ  per-requester last beat of packet
req_ready  out  NUM_REQ  per-requester beat accepted (one-hot or zero)
fifo_full  in  1  full flag from FIFO write controller
fifo_wr_en  out  1  FIFO write enable
fifo_wr_data  out  ID_WDTH+1+DATA_WDTH  {grant_id, last, payload}
busy  out  1  burst in progress

Behaviour:
- Reset value: clk and rst_n are already decided; rst_n is asynchronous and active-low on clk.
  - rst_n low or sync_rst_n low: state=IDLE, grant_id=0, beat_cnt=0, rr_ptr=NUM_REQ-1.
  - Outputs during reset: busy=0, fifo_wr_en=0, req_ready=0.
- FSM, two states:
  - IDLE: if any req_valid, select the first requester with valid high, searching upward from rr_ptr+1 modulo NUM_REQ. Register grant_id, set beat_cnt=0, go to BURST. No transfer occurs in IDLE (arbitration latency is 1 cycle).
  - BURST: busy=1. Transfer when xfer = req_valid[grant_id] & ~fifo_full.
    - On xfer: fifo_wr_en=1, req_ready[grant_id]=1, beat_cnt increments.
    - Exit to IDLE on an xfer where req_last[grant_id]=1 or beat_cnt==MAX_BURST-1; set rr_ptr=grant_id.
    - If req_valid[grant_id] drops with no xfer, stay in BURST (grant held; packets are not interleaved within a burst).
- Handshake timing:
  - fifo_wr_en and req_ready are combinational from the current state, req_valid and fifo_full.
  - fifo_wr_data is combinational: {grant_id, req_last[grant_id], req_data slice}.
  - A beat is accepted only when req_valid & req_ready are both high.
- fifo_full high: no write, no ready; grant and beat_cnt are held. Writing when full is never allowed.
- MAX_BURST cut mid-packet: a packet cut at the MAX_BURST limit resumes on the requester's next grant. The last bit in fifo_wr_data marks true packet ends only.
- MAX_BURST=1: every accepted beat returns to IDLE; the maximum write rate is one beat per 2 cycles.
- Fairness: after requester k is served, k has lowest priority at the next arbitration. Worst-case wait is (NUM_REQ-1) bursts.
- beat_cnt width is $clog2(MAX_BURST)+1 and never wraps.
- Reset mid-burst: the burst is abandoned with no further write. Requesters must re-present the packet.

Optional Feature:
WR_ARB_STALL_CNT_EN. When defined, adds these output ports:
- stall_cnt (16 bits): saturating count of BURST cycles with req_valid[grant_id]=1 and fifo_full=1. It sticks at 0xFFFF.
- stall_clr (1-bit input): clears stall_cnt to 0 the next cycle; clear wins over increment.
- Both resets also clear stall_cnt.
When not defined, neither port nor the counter exists, and behaviour is otherwise identical.

Test Plan:
- Reset: rst_n low then released, all req_valid=0 -> busy=0, fifo_wr_en=0, req_ready=0000 for 10 cycles.
- Single requester: req 2 sends 3 beats A0,A1,A2 with last on A2, fifo_full=0 -> 1 idle cycle, then 3 consecutive writes tagged ID=2, last=0,0,1; back to IDLE.
- Round-robin: all 4 requesters hold continuous 1-beat packets (last=1) from reset -> grant order 0,1,2,3,0,1; one write every 2 cycles.
- Burst cut: req 1 sends 6-beat packet with MAX_BURST=4, req 3 idle -> 4 beats with last=0, IDLE cycle, regrant to 1, 2 beats with last on the 6th. With req 3 valid too, req 3's burst is inserted between the two parts.
- Full backpressure: fifo_full asserted for 5 cycles during beat 2 of a burst -> fifo_wr_en=0 and ready=0 for those 5 cycles, grant unchanged, beat 2 written on the cycle full deasserts. With WR_ARB_STALL_CNT_EN, stall_cnt=5.
- Reset mid-burst: sync_rst_n low for 1 cycle after beat 1 of 4 -> no write that cycle, state=IDLE, busy=0; next grant follows rr_ptr=NUM_REQ-1, so it goes to the lowest valid requester.

Source files
------------

// File: rtl/wr_fifo_arb.sv
`default_nettype none
// ============================================================================
// Module   : wr_fifo_arb
// Purpose  : Round-robin arbiter sharing one FIFO write port among NUM_REQ
//            requesters. A grant lasts until the requester's last-beat flag
//            or MAX_BURST beats, whichever is first. Writes are gated by
//            fifo_full. Each written word carries the source requester ID.
// Ports    : clk, rst_n (async, active-low), sync_rst_n (sync, active-low)
//            req_valid/req_data/req_last  per-requester beat inputs
//            req_ready                    per-requester accept (one-hot/zero)
//            fifo_full                    FIFO write-side full flag
//            fifo_wr_en/fifo_wr_data      FIFO write, {grant_id, last, data}
//            busy                         burst in progress
// Options  : WR_ARB_STALL_CNT_EN adds stall_clr input and 16-bit stall_cnt
//            output (saturating count of full-blocked burst cycles).
// Revision : 1.0 - initial release
// ============================================================================
module wr_fifo_arb #(
  parameter int  NUM_REQ   = 4,
  parameter int  DATA_WDTH = 8,
  parameter int  MAX_BURST = 4,
  localparam int ID_WDTH   = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           sync_rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*DATA_WDTH-1:0]   req_data,
  input  logic [NUM_REQ-1:0]             req_last,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic                           fifo_full,
  output logic                           fifo_wr_en,
  output logic [ID_WDTH+DATA_WDTH:0]     fifo_wr_data,
`ifdef WR_ARB_STALL_CNT_EN
  input  logic                           stall_clr,
  output logic [15:0]                    stall_cnt,
`endif
  output logic                           busy
);

  localparam int                CNT_WDTH    = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_WDTH-1:0] LAST_BEAT = CNT_WDTH'(MAX_BURST - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [ID_WDTH-1:0]   r_grant_id;
  logic [ID_WDTH-1:0]   w_grant_nxt;
  logic [CNT_WDTH-1:0]  r_beat_cnt;
  logic [CNT_WDTH-1:0]  w_cnt_nxt;
  logic [ID_WDTH-1:0]   r_rr_ptr;
  logic [ID_WDTH-1:0]   w_rr_nxt;

  logic                 w_active;
  logic                 w_burst;
  logic                 w_xfer;
  logic                 w_found;
  logic [ID_WDTH-1:0]   w_idx;
  logic [ID_WDTH-1:0]   w_sel;
  logic [DATA_WDTH-1:0] w_data_arr [NUM_REQ];

  // Unpack the flat payload bus so the granted slice is a plain array read.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign w_data_arr[g] = req_data[g*DATA_WDTH +: DATA_WDTH];
  end

  // Either reset masks the handshake immediately, so a burst interrupted by
  // sync_rst_n performs no write in the reset cycle.
  assign w_active = rst_n & sync_rst_n;
  assign w_burst  = w_active & (r_state == BURST);
  assign w_xfer   = w_burst & req_valid[r_grant_id] & ~fifo_full;

  assign busy         = w_burst;
  assign fifo_wr_en   = w_xfer;
  assign req_ready    = w_xfer ? (NUM_REQ'(1) << r_grant_id) : '0;
  assign fifo_wr_data = {r_grant_id, req_last[r_grant_id], w_data_arr[r_grant_id]};

  // Rotating priority search: first valid requester after rr_ptr, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_idx = ID_WDTH'((int'(r_rr_ptr) + i) % NUM_REQ);
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant_id;
    w_cnt_nxt   = r_beat_cnt;
    w_rr_nxt    = r_rr_ptr;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt = BURST;
          w_grant_nxt = w_sel;
          w_cnt_nxt   = '0;
        end
      end
      BURST: begin
        if (w_xfer) begin
          if (req_last[r_grant_id] || (r_beat_cnt == LAST_BEAT)) begin
            // Burst ends; a packet cut here resumes on its next grant.
            w_state_nxt = IDLE;
            w_rr_nxt    = r_grant_id;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt   = r_beat_cnt + 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_grant_id <= '0;
      r_beat_cnt <= '0;
      r_rr_ptr   <= ID_WDTH'(NUM_REQ - 1);
    end else if (!sync_rst_n) begin
      r_state    <= IDLE;
      r_grant_id <= '0;
      r_beat_cnt <= '0;
      r_rr_ptr   <= ID_WDTH'(NUM_REQ - 1);
    end else begin
      r_state    <= w_state_nxt;
      r_grant_id <= w_grant_nxt;
      r_beat_cnt <= w_cnt_nxt;
      r_rr_ptr   <= w_rr_nxt;
    end
  end

`ifdef WR_ARB_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (!sync_rst_n || stall_clr) begin
      r_stall_cnt <= '0;
    end else if (w_burst && req_valid[r_grant_id] && fifo_full &&
                 (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wr_fifo_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_wr_fifo_arb
// Purpose  : Self-checking bench for wr_fifo_arb with a cycle-level
//            behavioural model and per-requester beat sources.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wr_fifo_arb;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            sync_rst_n;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_last;
  logic [N-1:0]    req_ready;
  logic            fifo_full;
  logic            fifo_wr_en;
  logic [IW+DW:0]  fifo_wr_data;
  logic            busy;
`ifdef WR_ARB_STALL_CNT_EN
  logic            stall_clr;
  logic [15:0]     stall_cnt;
`endif

  always #5 clk = ~clk;

  wr_fifo_arb #(.NUM_REQ(N), .DATA_WDTH(DW), .MAX_BURST(MB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sync_rst_n   (sync_rst_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
`ifdef WR_ARB_STALL_CNT_EN
    .stall_clr    (stall_clr),
    .stall_cnt    (stall_cnt),
`endif
    .busy         (busy)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Per-requester packet sources (head/tail into fixed buffers).
  logic [DW-1:0] qd [N][32];
  bit            ql [N][32];
  int            qh [N];
  int            qt [N];

  // Model state: burst active, granted id, beats so far, last served id.
  bit m_busy;
  int m_gid, m_beats, m_prev, m_stall;

  // Log of writes observed on the DUT, checked against literal expectations.
  int lg_id [64];
  int lg_last [64];
  int lg_data [64];
  int lg_cyc [64];
  int nlog;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int r, input logic [DW-1:0] d, input bit l);
    qd[r][qt[r]] = d;
    ql[r][qt[r]] = l;
    qt[r]++;
  endtask

  task automatic clear_q();
    for (int r = 0; r < N; r++) begin
      qh[r] = 0;
      qt[r] = 0;
    end
  endtask

  task automatic model_reset();
    m_busy  = 0;
    m_gid   = 0;
    m_beats = 0;
    m_prev  = N - 1;
    m_stall = 0;
  endtask

  // One clock cycle: drive sources, compare DUT against model, advance model.
  task automatic step();
    bit on, ex_busy, ex_x, cur_last;
    logic [N-1:0]   ex_rdy;
    logic [IW+DW:0] ex_data;
    for (int r = 0; r < N; r++) begin
      req_valid[r]        = (qh[r] < qt[r]);
      req_data[r*DW +: DW] = req_valid[r] ? qd[r][qh[r]] : '0;
      req_last[r]         = req_valid[r] ? ql[r][qh[r]] : 1'b0;
    end
    #1;
    on       = rst_n && sync_rst_n;
    ex_busy  = on && m_busy;
    ex_x     = ex_busy && req_valid[m_gid] && !fifo_full;
    ex_rdy   = ex_x ? (N'(1) << m_gid) : '0;
    cur_last = ex_x ? ql[m_gid][qh[m_gid]] : 1'b0;
    chk("busy", 32'(busy), 32'(ex_busy));
    chk("wr_en", 32'(fifo_wr_en), 32'(ex_x));
    chk("ready", 32'(req_ready), 32'(ex_rdy));
    if (ex_x) begin
      ex_data = {IW'(m_gid), cur_last, qd[m_gid][qh[m_gid]]};
      chk("wr_data", 32'(fifo_wr_data), 32'(ex_data));
    end
`ifdef WR_ARB_STALL_CNT_EN
    chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
`endif
    if (fifo_wr_en && nlog < 64) begin
      lg_id[nlog]   = int'(fifo_wr_data[IW+DW:DW+1]);
      lg_last[nlog] = int'(fifo_wr_data[DW]);
      lg_data[nlog] = int'(fifo_wr_data[DW-1:0]);
      lg_cyc[nlog]  = cyc;
      nlog++;
    end
    @(posedge clk);
    if (!on) begin
      model_reset();
    end else begin
`ifdef WR_ARB_STALL_CNT_EN
      if (stall_clr) m_stall = 0;
      else if (m_busy && req_valid[m_gid] && fifo_full && m_stall < 65535) m_stall++;
`endif
      if (!m_busy) begin
        for (int k = 1; k <= N; k++) begin
          int r;
          r = (m_prev + k) % N;
          if (!m_busy && req_valid[r]) begin
            m_busy  = 1;
            m_gid   = r;
            m_beats = 0;
          end
        end
      end else if (ex_x) begin
        qh[m_gid]++;
        m_beats++;
        if (cur_last || m_beats == MB) begin
          m_busy = 0;
          m_prev = m_gid;
        end
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic sreset();
    clear_q();
    sync_rst_n = 1'b0;
    step();
    sync_rst_n = 1'b1;
    nlog = 0;
  endtask

  initial begin
    int start;
    rst_n      = 1'b0;
    sync_rst_n = 1'b1;
    req_valid  = '0;
    req_data   = '0;
    req_last   = '0;
    fifo_full  = 1'b0;
`ifdef WR_ARB_STALL_CNT_EN
    stall_clr  = 1'b0;
`endif
    clear_q();
    model_reset();
    nlog = 0;
    @(negedge clk);

    // Reset then 10 quiet cycles.
    for (int i = 0; i < 3; i++) step();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) step();
    chk("reset_no_writes", 32'(nlog), 32'd0);

    // Single requester, 3-beat packet.
    sreset();
    start = cyc;
    push(2, 8'hA0, 0); push(2, 8'hA1, 0); push(2, 8'hA2, 1);
    for (int i = 0; i < 6; i++) step();
    chk("single_count", 32'(nlog), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk("single_id", 32'(lg_id[i]), 32'd2);
      chk("single_last", 32'(lg_last[i]), (i == 2) ? 32'd1 : 32'd0);
      chk("single_data", 32'(lg_data[i]), 32'hA0 + 32'(i));
      chk("single_cyc", 32'(lg_cyc[i] - start), 32'(1 + i));
    end

    // Round-robin with 1-beat packets on every requester.
    sreset();
    start = cyc;
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < N; r++) push(r, 8'(r * 16 + k), 1);
    for (int i = 0; i < 18; i++) step();
    chk("rr_count", 32'(nlog), 32'd8);
    for (int i = 0; i < 6; i++) begin
      chk("rr_id", 32'(lg_id[i]), 32'(i % N));
      chk("rr_cyc", 32'(lg_cyc[i] - start), 32'(1 + 2 * i));
    end

    // Burst cut at MAX_BURST, requester 1 alone.
    sreset();
    start = cyc;
    for (int i = 0; i < 6; i++) push(1, 8'h10 + 8'(i), i == 5);
    for (int i = 0; i < 10; i++) step();
    chk("cut_count", 32'(nlog), 32'd6);
    for (int i = 0; i < 6; i++) begin
      chk("cut_id", 32'(lg_id[i]), 32'd1);
      chk("cut_last", 32'(lg_last[i]), (i == 5) ? 32'd1 : 32'd0);
      chk("cut_cyc", 32'(lg_cyc[i] - start), (i < 4) ? 32'(1 + i) : 32'(2 + i));
    end

    // Burst cut with requester 3 inserted between the two parts.
    sreset();
    for (int i = 0; i < 6; i++) push(1, 8'h10 + 8'(i), i == 5);
    push(3, 8'h30, 0); push(3, 8'h31, 1);
    for (int i = 0; i < 14; i++) step();
    chk("cut2_count", 32'(nlog), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk("cut2_id", 32'(lg_id[i]), (i == 4 || i == 5) ? 32'd3 : 32'd1);
      chk("cut2_last", 32'(lg_last[i]), (i == 5 || i == 7) ? 32'd1 : 32'd0);
    end
    chk("cut2_data4", 32'(lg_data[4]), 32'h30);
    chk("cut2_data6", 32'(lg_data[6]), 32'h14);

    // Full backpressure for 5 cycles after two beats.
    sreset();
    start = cyc;
    for (int i = 0; i < 4; i++) push(0, 8'h50 + 8'(i), i == 3);
    for (int s = 0; s < 12; s++) begin
      fifo_full = (s >= 3 && s <= 7);
      step();
    end
    fifo_full = 1'b0;
    chk("full_count", 32'(nlog), 32'd4);
    chk("full_cyc0", 32'(lg_cyc[0] - start), 32'd1);
    chk("full_cyc1", 32'(lg_cyc[1] - start), 32'd2);
    chk("full_cyc2", 32'(lg_cyc[2] - start), 32'd8);
    chk("full_cyc3", 32'(lg_cyc[3] - start), 32'd9);
    chk("full_data2", 32'(lg_data[2]), 32'h52);
`ifdef WR_ARB_STALL_CNT_EN
    chk("stall_five", 32'(stall_cnt), 32'd5);
    stall_clr = 1'b1;
    step();
    stall_clr = 1'b0;
    chk("stall_clr", 32'(stall_cnt), 32'd0);
`endif

    // Synchronous reset mid-burst.
    sreset();
    start = cyc;
    for (int i = 0; i < 4; i++) push(2, 8'h60 + 8'(i), i == 3);
    step();
    step();
    sync_rst_n = 1'b0;
    step();
    sync_rst_n = 1'b1;
    chk("srst_busy", 32'(busy), 32'd0);
    clear_q();
    for (int i = 0; i < 4; i++) push(2, 8'h60 + 8'(i), i == 3);
    push(1, 8'h70, 0); push(1, 8'h71, 1);
    for (int i = 0; i < 10; i++) step();
    chk("srst_first_id", 32'(lg_id[0]), 32'd2);
    chk("srst_first_cyc", 32'(lg_cyc[0] - start), 32'd1);
    chk("srst_next_id", 32'(lg_id[1]), 32'd1);
    chk("srst_next_data", 32'(lg_data[1]), 32'h70);
    chk("srst_next_cyc", 32'(lg_cyc[1] - start), 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
